// File: rtl/pll_rst_seq.sv
// Staged reset sequencer: qualifies PLL lock, releases the phy reset and then the
// core reset, and records sticky lock-loss information.
module pll_rst_seq #(
   parameter int STABLE_CYC = 1024,
   parameter int STAGE_GAP  = 16,
   parameter int CNT_W      = 8
) (
   input  logic             LS_CLK,
   input  logic             nRST,
   input  logic             lock,
   input  logic             sw_rst,
   input  logic             clr_sticky,
   output logic             nRST_phy,
   output logic             nRST_core,
   output logic             ready,
   output logic             lock_lost,
   output logic [CNT_W-1:0] loss_cnt,
   output logic [1:0]       state
);

   localparam int MAX_CYC = (STABLE_CYC > STAGE_GAP) ? STABLE_CYC : STAGE_GAP;
   localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic          sync1_reg;
   logic          sync2_reg;
   logic          loss;

   // Lock is only a loss once at least the phy reset has been let go.
   assign loss  = ((state_reg == RELEASE) || (state_reg == RUN)) && !sync2_reg;
   assign state = state_reg;

   always_ff @(posedge LS_CLK or negedge nRST) begin
      if (!nRST) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         state_reg <= WAIT_LOCK;
         cnt_reg   <= '0;
         nRST_phy  <= 1'b0;
         nRST_core <= 1'b0;
         ready     <= 1'b0;
         lock_lost <= 1'b0;
         loss_cnt  <= '0;
      end else begin
         sync1_reg <= lock;
         sync2_reg <= sync1_reg;

         if (loss) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= '0;
            nRST_phy  <= 1'b0;
            nRST_core <= 1'b0;
            ready     <= 1'b0;
            lock_lost <= 1'b1;
            // A simultaneous clear wipes the old count before this loss is added.
            if (clr_sticky)
               loss_cnt <= CNT_W'(1);
            else if (loss_cnt != {CNT_W{1'b1}})
               loss_cnt <= loss_cnt + 1'b1;
         end else begin
            if (clr_sticky) begin
               lock_lost <= 1'b0;
               loss_cnt  <= '0;
            end

            if (sw_rst) begin
               state_reg <= WAIT_LOCK;
               cnt_reg   <= '0;
               nRST_phy  <= 1'b0;
               nRST_core <= 1'b0;
               ready     <= 1'b0;
            end else begin
               case (state_reg)
                  WAIT_LOCK: begin
                     cnt_reg   <= '0;
                     nRST_phy  <= 1'b0;
                     nRST_core <= 1'b0;
                     ready     <= 1'b0;
                     if (sync2_reg)
                        state_reg <= STABLE;
                  end
                  STABLE: begin
                     if (!sync2_reg) begin
                        state_reg <= WAIT_LOCK;
                        cnt_reg   <= '0;
                     end else if (cnt_reg == STABLE_LAST) begin
                        state_reg <= RELEASE;
                        cnt_reg   <= '0;
                        nRST_phy  <= 1'b1;
                     end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                     end
                  end
                  RELEASE: begin
                     nRST_phy <= 1'b1;
                     if (cnt_reg == GAP_LAST) begin
                        state_reg <= RUN;
                        cnt_reg   <= '0;
                        nRST_core <= 1'b1;
                        ready     <= 1'b1;
                     end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                     end
                  end
                  default: begin
                     state_reg <= RUN;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed scenarios plus random lock/sw_rst/clr_sticky
// traffic, checked every cycle against a timeline model of the release sequence.
module tb_pll_rst_seq;
   localparam int SC   = 8;
   localparam int GAP  = 4;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          LS_CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          lock = 1'b0;
   logic          sw_rst = 1'b0;
   logic          clr_sticky = 1'b0;
   logic          nRST_phy;
   logic          nRST_core;
   logic          ready;
   logic          lock_lost;
   logic [CW-1:0] loss_cnt;
   logic [1:0]    state;

   pll_rst_seq #(.STABLE_CYC(SC), .STAGE_GAP(GAP), .CNT_W(CW)) dut (
      .LS_CLK(LS_CLK), .nRST(nRST), .lock(lock), .sw_rst(sw_rst),
      .clr_sticky(clr_sticky), .nRST_phy(nRST_phy), .nRST_core(nRST_core),
      .ready(ready), .lock_lost(lock_lost), .loss_cnt(loss_cnt), .state(state)
   );

   always #5 LS_CLK = ~LS_CLK;

   int checks = 0;
   int errors = 0;

   // Model: age = edges since E (first edge seeing synchronized lock), -1 when idle.
   int   age;
   logic lk1, lk2;
   logic m_lost;
   int   m_cnt;

   task automatic model_reset();
      age = -1; lk1 = 1'b0; lk2 = 1'b0; m_lost = 1'b0; m_cnt = 0;
   endtask

   task automatic model_edge();
      logic ls;
      if (!nRST) begin
         model_reset();
         return;
      end
      ls  = lk2;
      lk2 = lk1;
      lk1 = lock;
      if (age >= SC && !ls) begin
         age    = -1;
         m_lost = 1'b1;
         m_cnt  = clr_sticky ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
      end else begin
         if (sw_rst)               age = -1;
         else if (age < 0)         age = ls ? 0 : -1;
         else if (age < SC)        age = ls ? age + 1 : -1;
         else if (age < SC + GAP)  age = age + 1;
         if (clr_sticky) begin
            m_lost = 1'b0;
            m_cnt  = 0;
         end
      end
   endtask

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_all();
      int es;
      es = (age < 0) ? 0 : (age < SC) ? 1 : (age < SC + GAP) ? 2 : 3;
      chk("nRST_phy",  {7'd0, nRST_phy},  {7'd0, age >= SC});
      chk("nRST_core", {7'd0, nRST_core}, {7'd0, age >= SC + GAP});
      chk("ready",     {7'd0, ready},     {7'd0, age >= SC + GAP});
      chk("lock_lost", {7'd0, lock_lost}, {7'd0, m_lost});
      chk("loss_cnt",  {6'd0, loss_cnt},  8'(m_cnt));
      chk("state",     {6'd0, state},     8'(es));
      chk("invariant", {7'd0, nRST_core & ~nRST_phy}, 8'd0);
   endtask

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge LS_CLK);
         model_edge();
         #1;
         check_all();
         $display("t=%0t lock=%0b sw=%0b clr=%0b phy=%0b core=%0b rdy=%0b lost=%0b cnt=%0d st=%0d",
                  $time, lock, sw_rst, clr_sticky, nRST_phy, nRST_core, ready,
                  lock_lost, loss_cnt, state);
         sw_rst     = 1'b0;
         clr_sticky = 1'b0;
      end
   endtask

   initial begin
      model_reset();
      #2;
      check_all();
      @(negedge LS_CLK);
      nRST = 1'b1;
      cyc(2);

      // 1: lock rises and is held through the full staged release
      lock = 1'b1;
      cyc(2 + SC + GAP + 3);

      // 2: lock drops for 3 cycles at the 5th STABLE cycle
      sw_rst = 1'b1;
      cyc(1);
      cyc(5);
      lock = 1'b0;
      cyc(3);
      lock = 1'b1;
      cyc(SC + GAP + 6);

      // 3: lock loss in RUN, then normal release
      lock = 1'b0;
      cyc(4);
      lock = 1'b1;
      cyc(SC + GAP + 4);

      // 4: five losses from RUN, counter saturates, then clear
      clr_sticky = 1'b1;
      cyc(1);
      repeat (5) begin
         lock = 1'b0;
         cyc(3);
         lock = 1'b1;
         cyc(SC + GAP + 3);
      end
      clr_sticky = 1'b1;
      cyc(2);

      // 5: sw_rst in RUN; sw_rst coincident with loss; loss coincident with clear
      sw_rst = 1'b1;
      cyc(1);
      cyc(SC + GAP + 4);
      lock = 1'b0;
      cyc(2);
      sw_rst = 1'b1;
      cyc(1);
      lock = 1'b1;
      cyc(SC + GAP + 4);
      lock = 1'b0;
      cyc(2);
      clr_sticky = 1'b1;
      cyc(1);
      lock = 1'b1;
      cyc(SC + GAP + 4);

      // 6: async reset asserted during RELEASE
      sw_rst = 1'b1;
      cyc(1);
      cyc(SC + 2);
      #2;
      nRST = 1'b0;
      #1;
      model_reset();
      check_all();
      cyc(2);
      #2;
      nRST = 1'b1;
      cyc(SC + GAP + 4);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) lock = ~lock;
         if ($urandom_range(0, 39) == 0) sw_rst = 1'b1;
         if ($urandom_range(0, 29) == 0) clr_sticky = 1'b1;
         cyc(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end
endmodule
